// File: rtl/element_wise_seq_if.sv
// element_wise_seq_if: buffer-read, element-wise PE and write-back signals of the LSTM element-wise sequencer.
interface element_wise_seq_if #(
    parameter int DATA_WIDTH   = 12,
    parameter int ADDRESS_BITS = 12
);
    logic                    go;
    logic [ADDRESS_BITS-1:0] length;
    logic                    hold;
    logic                    busy;
    logic                    done;
    logic                    rd_en;
    logic [ADDRESS_BITS-1:0] rd_addr;
    logic [DATA_WIDTH-1:0]   i_rdata, f_rdata, g_rdata, o_rdata, c_prev_rdata;
    logic                    ew_start;
    logic [DATA_WIDTH-1:0]   ew_i, ew_f, ew_g, ew_o, ew_c_prev;
    logic [DATA_WIDTH-1:0]   ew_ct, ew_ht;
    logic                    wr_en;
    logic [ADDRESS_BITS-1:0] wr_addr;
    logic [DATA_WIDTH-1:0]   c_wdata, h_wdata;
    logic [ADDRESS_BITS-1:0] elem_count;
    modport master (
        input  go, length, hold, i_rdata, f_rdata, g_rdata, o_rdata, c_prev_rdata, ew_ct, ew_ht,
        output busy, done, rd_en, rd_addr, ew_start, ew_i, ew_f, ew_g, ew_o, ew_c_prev,
               wr_en, wr_addr, c_wdata, h_wdata, elem_count
    );
    modport slave (
        output go, length, hold, i_rdata, f_rdata, g_rdata, o_rdata, c_prev_rdata, ew_ct, ew_ht,
        input  busy, done, rd_en, rd_addr, ew_start, ew_i, ew_f, ew_g, ew_o, ew_c_prev,
               wr_en, wr_addr, c_wdata, h_wdata, elem_count
    );
endinterface

// File: rtl/element_wise_seq.sv
// element_wise_seq: streams i/f/g/o/c_prev elements into the element-wise PE and writes C(t)/h(t) back.
module element_wise_seq #(
    parameter int DATA_WIDTH   = 12,
    parameter int ADDRESS_BITS = 12
) (
    input logic                clk,
    input logic                rst,
    element_wise_seq_if.master bus
);
    localparam logic [1:0] IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2, DONE = 2'd3;
    logic [1:0]              state_q, state_d;
    logic [ADDRESS_BITS-1:0] len_q, len_d, rd_addr_q, rd_addr_d, cnt_q, cnt_d;
    logic                    v1_q, v1_d, v2_q, v2_d;
    logic [5*DATA_WIDTH-1:0] ops_q, ops_d;
    logic                    accept, issue, last, wr;
    always_comb begin
        accept    = state_q == IDLE && bus.go;
        issue     = state_q == RUN && !bus.hold;
        last      = issue && rd_addr_q == len_q - 1'b1;
        wr        = v2_q && !bus.hold && !rst;
        len_d     = accept ? bus.length : len_q;
        rd_addr_d = accept ? '0 : (issue && !last) ? rd_addr_q + 1'b1 : rd_addr_q;
        cnt_d     = accept ? '0 : wr ? cnt_q + 1'b1 : cnt_q;
        v1_d      = bus.hold ? v1_q : issue;
        v2_d      = bus.hold ? v2_q : v1_q;
        ops_d     = (bus.hold || !v1_q) ? ops_q
                  : {bus.i_rdata, bus.f_rdata, bus.g_rdata, bus.o_rdata, bus.c_prev_rdata};
        state_d   = state_q;
        case (state_q)
            IDLE:    state_d = accept ? (bus.length == '0 ? DONE : RUN) : IDLE;
            RUN:     state_d = last ? DRAIN : RUN;
            // the final write is taking place on this edge
            DRAIN:   state_d = (v2_q && !v1_q && !bus.hold) ? DONE : DRAIN;
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            len_q     <= '0;
            rd_addr_q <= '0;
            cnt_q     <= '0;
            v1_q      <= 1'b0;
            v2_q      <= 1'b0;
            ops_q     <= '0;
        end else begin
            state_q   <= state_d;
            len_q     <= len_d;
            rd_addr_q <= rd_addr_d;
            cnt_q     <= cnt_d;
            v1_q      <= v1_d;
            v2_q      <= v2_d;
            ops_q     <= ops_d;
        end
    end
    assign bus.busy       = state_q == RUN || state_q == DRAIN;
    assign bus.done       = state_q == DONE;
    assign bus.rd_en      = issue;
    assign bus.rd_addr    = rd_addr_q;
    assign bus.ew_start   = v2_q;
    assign {bus.ew_i, bus.ew_f, bus.ew_g, bus.ew_o, bus.ew_c_prev} = v2_q ? ops_q : '0;
    assign bus.wr_en      = wr;
    // writes complete strictly in order, so the running count is the write address
    assign bus.wr_addr    = cnt_q;
    assign bus.elem_count = cnt_q;
    assign bus.c_wdata    = bus.ew_ct;
    assign bus.h_wdata    = bus.ew_ht;
endmodule
